// File: rtl/bus_resp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : bus_resp_pkg
// Brief    : Shared types and default constants for the bus request responder.
// Revision : 1.0 - initial release
// ============================================================================
package bus_resp_pkg;

    // Default build-time parameters of the responder
    localparam int BUS_RESP_DATA_WIDTH = 32;
    localparam int BUS_RESP_DEPTH      = 4;
    localparam int BUS_RESP_ACK_DELAY  = 2;

    // Width of the ack delay counter; bounds ACK_DELAY to 1..255
    localparam int BUS_RESP_CNT_W      = 8;

    // Responder sequencing states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } bus_resp_state_t;

endpackage : bus_resp_pkg
`default_nettype wire

// File: rtl/bus_resp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : bus_resp_fifo
// Brief    : Synchronous DEPTH x DATA_WIDTH queue of pending requests. A push
//            and a pop on the same edge are both honoured, even when full.
// Revision : 1.0 - initial release
// ============================================================================
module bus_resp_fifo #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       push,
    input  logic [DATA_WIDTH-1:0]      push_data,
    input  logic                       pop,
    output logic [DATA_WIDTH-1:0]      head,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int                 c_PTR_W = $clog2(DEPTH);
    localparam logic [c_PTR_W:0]   c_FULL  = DEPTH[c_PTR_W:0];

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr;
    logic [c_PTR_W-1:0]    r_rd_ptr;
    logic [c_PTR_W:0]      r_count;
    logic                  w_do_push;
    logic                  w_do_pop;

    assign full      = (r_count == c_FULL);
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head      = r_mem[r_rd_ptr];

    // A pop frees the slot this edge, so a push into a full queue is allowed with it
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // Storage array; contents need no reset because occupancy gates every read
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : bus_resp_fifo
`default_nettype wire

// File: rtl/bus_req_responder.sv
`default_nettype none
// ============================================================================
// Module   : bus_req_responder
// Brief    : Slave-side responder for the pulse request/ack bus. Queues
//            accepted requests and returns one registered ack per request a
//            fixed ACK_DELAY cycles after the previous ack or acceptance.
// Revision : 1.0 - initial release
// ============================================================================
module bus_req_responder
    import bus_resp_pkg::*;
#(
    parameter int DATA_WIDTH = BUS_RESP_DATA_WIDTH,
    parameter int DEPTH      = BUS_RESP_DEPTH,
    parameter int ACK_DELAY  = BUS_RESP_ACK_DELAY
) (
    input  logic                       clk,
    input  logic                       reset_l,
    input  logic                       bus_req,
    input  logic [DATA_WIDTH-1:0]      bus_data,
    output logic                       bus_ack,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [$clog2(DEPTH):0]     pending,
    output logic                       err_overflow,
    output logic                       err_protocol,
    output logic [15:0]                txn_count
);

    // Load values: from IDLE the ack lands ACK_DELAY edges after acceptance;
    // from ACK one edge of the delay has already elapsed in the ACK cycle.
    localparam logic [BUS_RESP_CNT_W-1:0] c_LOAD_FIRST =
        ACK_DELAY[BUS_RESP_CNT_W-1:0] - 8'd1;
    localparam logic [BUS_RESP_CNT_W-1:0] c_LOAD_NEXT  =
        (ACK_DELAY > 1) ? (ACK_DELAY[BUS_RESP_CNT_W-1:0] - 8'd2) : 8'd0;

    bus_resp_state_t               r_state;
    bus_resp_state_t               w_state_nxt;
    logic [BUS_RESP_CNT_W-1:0]     r_cnt;
    logic [BUS_RESP_CNT_W-1:0]     w_cnt_nxt;
    logic                          r_req_d;
    logic                          w_accept;
    logic                          w_push;
    logic                          w_pop;
    logic                          w_full;
    logic                          w_empty;
    logic [DATA_WIDTH-1:0]         w_head;

    // Only a rising request is a new transaction; a held request is a protocol error
    assign w_accept = bus_req & ~r_req_d;
    assign w_push   = w_accept & (~w_full | w_pop);

    bus_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_l   (reset_l),
        .push      (w_push),
        .push_data (bus_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_full),
        .empty     (w_empty),
        .count     (pending)
    );

    // Next-state logic; the head is popped on the edge that enters ACK
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = c_LOAD_FIRST;
                end
            end
            WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ACK;
                    w_pop       = 1'b1;
                end else begin
                    w_cnt_nxt   = r_cnt - 1'b1;
                end
            end
            ACK: begin
                if (!w_empty) begin
                    if (ACK_DELAY == 1) begin
                        w_state_nxt = ACK;
                        w_pop       = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_LOAD_NEXT;
                    end
                end else if (w_accept) begin
                    w_state_nxt = WAIT;
                    w_cnt_nxt   = c_LOAD_FIRST;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State, delay counter and request edge tracker
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_req_d <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_req_d <= bus_req;
        end
    end

    // Registered outputs: ack pulse, response data, error pulses, ack counter
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            bus_ack      <= 1'b0;
            rsp_data     <= '0;
            err_overflow <= 1'b0;
            err_protocol <= 1'b0;
            txn_count    <= '0;
        end else begin
            bus_ack      <= w_pop;
            err_overflow <= w_accept & w_full & ~w_pop;
            err_protocol <= bus_req & r_req_d;
            if (w_pop) begin
                rsp_data  <= w_head;
                txn_count <= txn_count + 16'd1;
            end
        end
    end

endmodule : bus_req_responder
`default_nettype wire
